// File: rtl/uart_rx_frame.sv
`default_nettype none
// uart_rx_frame: one-sample-per-clk serial frame receiver (idle 0, start 1, LSB-first data, stop 0).
// Optional parity bit between data and stop bits when UART_PARITY_EN is defined.
// Revision: 1.0
module uart_rx_frame #(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              signal,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int BCNT_W = $clog2(DATA_W + 1);
  localparam int SCNT_W = $clog2(STOP_BITS + 1);

  localparam logic [BCNT_W-1:0] c_last_bit  = BCNT_W'(DATA_W - 1);
  localparam logic [SCNT_W-1:0] c_last_stop = SCNT_W'(STOP_BITS - 1);
  localparam logic              c_par_odd   = 1'(PARITY_ODD);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_data   = 2'd1;
  localparam logic [1:0] c_parity = 2'd2;
  localparam logic [1:0] c_stop   = 2'd3;

`ifdef UART_PARITY_EN
  localparam logic [1:0] c_after_data = c_parity;
`else
  localparam logic [1:0] c_after_data = c_stop;
`endif

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [BCNT_W-1:0] r_bit_cnt;
  logic [SCNT_W-1:0] r_stop_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic              r_frame_flag;
  logic              w_frame_bad;
  logic              w_par_bad;
  logic              w_last_stop;
  logic              w_busy;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_frame_err;
  logic              r_parity_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_idle;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:   if (signal) w_next = c_data;
      c_data:   if (r_bit_cnt == c_last_bit) w_next = c_after_data;
      c_parity: w_next = c_stop;
      c_stop:   if (r_stop_cnt == c_last_stop) w_next = c_idle;
      default:  w_next = c_idle;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != c_idle);
    w_last_stop = (r_state == c_stop) && (r_stop_cnt == c_last_stop);
    // A 1 on the current (last) stop sample counts toward the outcome too.
    w_frame_bad = r_frame_flag | signal;
  end

  always_comb begin
    w_shift_next = r_shift;
    for (int i = 0; i < DATA_W; i++)
      if (r_bit_cnt == BCNT_W'(i)) w_shift_next[i] = signal;
  end

`ifdef UART_PARITY_EN
  logic r_par_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par_acc <= 1'b0;
    end else begin
      case (r_state)
        c_idle:           r_par_acc <= 1'b0;
        c_data, c_parity: r_par_acc <= r_par_acc ^ signal;
        default:          r_par_acc <= r_par_acc;
      endcase
    end
  end

  assign w_par_bad = r_par_acc ^ c_par_odd;
`else
  assign w_par_bad = 1'b0 & c_par_odd;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt    <= '0;
      r_stop_cnt   <= '0;
      r_shift      <= '0;
      r_frame_flag <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      case (r_state)
        c_idle: begin
          r_bit_cnt    <= '0;
          r_stop_cnt   <= '0;
          r_frame_flag <= 1'b0;
        end
        c_data: begin
          r_shift   <= w_shift_next;
          r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
        end
        c_stop: begin
          r_stop_cnt   <= r_stop_cnt + SCNT_W'(1);
          r_frame_flag <= w_frame_bad;
          if (w_last_stop) begin
            r_frame_err  <= w_frame_bad;
            r_parity_err <= w_par_bad;
            if (!w_frame_bad && !w_par_bad) begin
              r_valid <= 1'b1;
              r_data  <= r_shift;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign valid      = r_valid;
  assign data       = r_data;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// tb_uart_rx_frame: directed vector table, a DATA_W=4/STOP_BITS=2 instance, and random
// bit streams checked against a frame-level decoder model.
module tb_uart_rx_frame;

  localparam int DW   = 8;
  localparam int SB   = 1;
  localparam int PODD = 0;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = DW + PB + SB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          signal = 1'b0;
  logic          sig2 = 1'b0;
  logic          valid, frame_err, parity_err, busy;
  logic [DW-1:0] data;
  logic          valid2, ferr2, perr2, busy2;
  logic [3:0]    data2;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_frame #(.DATA_W(DW), .STOP_BITS(SB), .PARITY_ODD(PODD)) dut (
    .clk(clk), .reset(reset), .signal(signal), .valid(valid), .data(data),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  uart_rx_frame #(.DATA_W(4), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
    .clk(clk), .reset(reset), .signal(sig2), .valid(valid2), .data(data2),
    .frame_err(ferr2), .parity_err(perr2), .busy(busy2)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          sig;
    logic          valid;
    logic [DW-1:0] data;
    logic          ferr;
    logic          perr;
    logic          busy;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] t_hold;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic v, input logic [DW-1:0] d,
                     input logic fe, input logic pe, input logic b);
    vec_t x;
    x.rst = r; x.sig = s; x.valid = v; x.data = d; x.ferr = fe; x.perr = pe; x.busy = b;
    tbl.push_back(x);
  endtask

  // ndata < DW truncates the frame after that many data bits
  task automatic add_frame(input logic [DW-1:0] w, input logic bad_stop, input logic par_flip,
                           input int ndata);
    logic bad;
    add(1'b0, 1'b1, 1'b0, t_hold, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < ndata; j++) add(1'b0, w[j], 1'b0, t_hold, 1'b0, 1'b0, 1'b1);
    if (ndata < DW) return;
    if (PB != 0) add(1'b0, (^w) ^ PODD[0] ^ par_flip, 1'b0, t_hold, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < SB - 1; j++) add(1'b0, 1'b0, 1'b0, t_hold, 1'b0, 1'b0, 1'b1);
    bad = bad_stop | (par_flip & (PB != 0));
    if (!bad) t_hold = w;
    add(1'b0, bad_stop, !bad, t_hold, bad_stop, par_flip & (PB != 0), 1'b0);
  endtask

  task automatic run_table();
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      reset  = tbl[k].rst;
      signal = tbl[k].sig;
      @(posedge clk); #1;
      chk("vec_valid", k, valid,      tbl[k].valid);
      chk("vec_data",  k, data,       tbl[k].data);
      chk("vec_ferr",  k, frame_err,  tbl[k].ferr);
      chk("vec_perr",  k, parity_err, tbl[k].perr);
      chk("vec_busy",  k, busy,       tbl[k].busy);
    end
    @(negedge clk);
    reset = 1'b0; signal = 1'b0;
  endtask

  // DATA_W=4, STOP_BITS=2 instance: start, 0,0,1,1 (4'hC), [parity 0], stop, stop
  task automatic run_narrow(input logic last_stop, input logic exp_v, input logic exp_fe, input int tag);
    logic b[$];
    b = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    if (PB != 0) b.push_back(1'b0);
    b.push_back(1'b0);
    b.push_back(last_stop);
    for (int k = 0; k < b.size(); k++) begin
      @(negedge clk); sig2 = b[k];
      @(posedge clk); #1;
      if (k < b.size() - 1) begin
        chk("w4_valid_mid", tag * 16 + k, valid2, 1'b0);
        chk("w4_busy_mid",  tag * 16 + k, busy2,  1'b1);
      end
    end
    chk("w4_valid", tag, valid2, exp_v);
    chk("w4_ferr",  tag, ferr2,  exp_fe);
    chk("w4_data",  tag, data2,  4'hC);
    chk("w4_busy",  tag, busy2,  1'b0);
    @(negedge clk); sig2 = 1'b0;
    @(posedge clk); #1;
    chk("w4_pulse_end", tag, valid2 | ferr2, 1'b0);
  endtask

  // mode 0: well-formed frames with occasional bad stop/parity; mode 1: raw random bits
  task automatic run_random(input int mode, input int nframes, input int tag);
    logic          s[$];
    logic          ev[], ef[], ep[], eb[];
    logic [DW-1:0] ew[], ed[];
    logic [DW-1:0] w, hold;
    logic          fbad, pbad;
    int            n, p, o;
    if (mode == 0) begin
      for (int f = 0; f < nframes; f++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) s.push_back(1'b0);
        w = DW'($urandom);
        s.push_back(1'b1);
        for (int j = 0; j < DW; j++) s.push_back(w[j]);
        if (PB != 0) s.push_back((^w) ^ PODD[0] ^ ($urandom_range(0, 7) == 0));
        for (int j = 0; j < SB; j++) s.push_back($urandom_range(0, 7) == 0);
      end
    end else begin
      for (int k = 0; k < nframes * FL; k++) s.push_back(1'($urandom));
    end
    for (int k = 0; k < 3; k++) s.push_back(1'b0);
    n = s.size();
    ev = new[n]; ef = new[n]; ep = new[n]; eb = new[n]; ew = new[n]; ed = new[n];
    for (int c = 0; c < n; c++) begin
      ev[c] = 0; ef[c] = 0; ep[c] = 0; eb[c] = 0; ew[c] = '0;
    end
    p = 0;
    while (p < n) begin
      if (s[p] && (p + FL < n)) begin
        for (int j = 0; j < DW; j++) w[j] = s[p + 1 + j];
        fbad = 1'b0;
        for (int j = 0; j < SB; j++) fbad |= s[p + 1 + DW + PB + j];
        pbad = (PB != 0) ? ((^w) ^ s[p + 1 + DW] ^ PODD[0]) : 1'b0;
        for (int q = p; q < p + FL; q++) eb[q] = 1'b1;
        o = p + FL;
        ef[o] = fbad; ep[o] = pbad; ev[o] = !fbad && !pbad; ew[o] = w;
        p = o + 1;
      end else if (s[p]) begin
        for (int q = p; q < n; q++) eb[q] = 1'b1;
        p = n;
      end else begin
        p++;
      end
    end
    hold = '0;
    for (int c = 0; c < n; c++) begin
      if (ev[c]) hold = ew[c];
      ed[c] = hold;
    end
    @(negedge clk); reset = 1'b1; signal = 1'b0;
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk); signal = s[c];
      @(posedge clk); #1;
      chk("rnd_valid", tag * 100000 + c, valid,      ev[c]);
      chk("rnd_data",  tag * 100000 + c, data,       ed[c]);
      chk("rnd_ferr",  tag * 100000 + c, frame_err,  ef[c]);
      chk("rnd_perr",  tag * 100000 + c, parity_err, ep[c]);
      chk("rnd_busy",  tag * 100000 + c, busy,       eb[c]);
    end
    @(negedge clk); signal = 1'b0;
  endtask

  initial begin
    t_hold = '0;
    add(1'b0, 1'b0, 1'b0, t_hold, 1'b0, 1'b0, 1'b0);
    add_frame(8'h55, 1'b0, 1'b0, DW);
    add(1'b0, 1'b0, 1'b0, t_hold, 1'b0, 1'b0, 1'b0);
    add_frame(8'hA3, 1'b0, 1'b0, DW);
    add_frame(8'h0F, 1'b0, 1'b0, DW);
    add(1'b0, 1'b0, 1'b0, t_hold, 1'b0, 1'b0, 1'b0);
    add_frame(8'h55, 1'b1, 1'b0, DW);
    add(1'b0, 1'b0, 1'b0, t_hold, 1'b0, 1'b0, 1'b0);
    add_frame(8'h55, 1'b0, 1'b0, 4);
    t_hold = '0;
    add(1'b1, 1'b0, 1'b0, t_hold, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, t_hold, 1'b0, 1'b0, 1'b0);
    add_frame(8'h3C, 1'b0, 1'b0, DW);
    add(1'b0, 1'b0, 1'b0, t_hold, 1'b0, 1'b0, 1'b0);
`ifdef UART_PARITY_EN
    add_frame(8'h07, 1'b0, 1'b0, DW);
    add_frame(8'h07, 1'b0, 1'b1, DW);
    add_frame(8'h07, 1'b1, 1'b1, DW);
    add(1'b0, 1'b0, 1'b0, t_hold, 1'b0, 1'b0, 1'b0);
`endif

    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid", 0, valid,      1'b0);
    chk("rst_data",  0, data,       '0);
    chk("rst_ferr",  0, frame_err,  1'b0);
    chk("rst_perr",  0, parity_err, 1'b0);
    chk("rst_busy",  0, busy,       1'b0);
    chk("rst_busy2", 0, busy2,      1'b0);

    run_table();
    run_narrow(1'b0, 1'b1, 1'b0, 0);
    run_narrow(1'b1, 1'b0, 1'b1, 1);
    run_random(0, 40, 0);
    run_random(1, 25, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
